muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 8 +
 rtl/muldiv_unit.sv | 80 ++++++++
 tb/tb_muldiv_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage request/response bundle for the multi-cycle RV32M unit
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic md_valid, md_ready, flush, md_busy, md_done;
  logic [2:0] md_op;
  logic [XLEN-1:0] op_A, op_B, md_o;
  modport master (output md_valid, md_op, op_A, op_B, flush, input md_ready, md_busy, md_done, md_o);
  modport slave (input md_valid, md_op, op_A, op_B, flush, output md_ready, md_busy, md_done, md_o);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide on one shift-add / restoring-subtract datapath
module muldiv_unit #(parameter int XLEN = 32) (
  input logic clk,
  input logic rstn,
  muldiv_unit_if.slave md
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op;
  logic neg_a, neg_b, special, done, accept;
  logic a_signed, b_signed, in_neg_a, in_neg_b, div_zero, div_ovf;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_n, prod;
  logic [XLEN-1:0] opb, last, rem, quo, result, abs_a, abs_b;
  logic [XLEN:0] sum, shifted, diff;
  always_comb begin
    a_signed = !(md.md_op[0] & (md.md_op[1] | md.md_op[2]));
    b_signed = md.md_op[2] ? !md.md_op[0] : !md.md_op[1];
    in_neg_a = a_signed & md.op_A[XLEN-1];
    in_neg_b = b_signed & md.op_B[XLEN-1];
    abs_a = in_neg_a ? -md.op_A : md.op_A;
    abs_b = in_neg_b ? -md.op_B : md.op_B;
    div_zero = md.md_op[2] & (md.op_B == '0);
    div_ovf = md.md_op[2] & !md.md_op[0] & (md.op_A == {1'b1, {(XLEN-1){1'b0}}}) & (&md.op_B);
    accept = md.md_valid & (state == IDLE) & !md.flush;
  end
  // acc holds {hi, multiplier} for multiplies and {remainder, quotient} for divides
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    shifted = acc[2*XLEN-1:XLEN-1];
    diff = shifted - {1'b0, opb};
    acc_n = !op[2] ? {sum, acc[XLEN-1:1]} :
            diff[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    prod = (neg_a ^ neg_b) ? -acc : acc;
    quo = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    result = !op[2] ? (op[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) : op[1] ? rem : quo;
  end
  // specials spend one CALC cycle so their pulse lands one cycle after accept
  always_comb begin
    state_n = md.flush ? IDLE :
              state == IDLE ? (accept ? CALC : IDLE) :
              state == CALC ? ((special || cnt == CW'(XLEN-1)) ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      op <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      special <= 1'b0;
      cnt <= '0;
      acc <= '0;
      opb <= '0;
      last <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op <= md.md_op;
        special <= div_zero | div_ovf;
        neg_a <= in_neg_a & !(div_zero | div_ovf);
        neg_b <= in_neg_b & !(div_zero | div_ovf);
        cnt <= '0;
        opb <= md.md_op[2] ? abs_b : abs_a;
        acc <= div_zero ? {md.op_A, {XLEN{1'b1}}} :
               div_ovf ? {{XLEN{1'b0}}, md.op_A} :
               {{XLEN{1'b0}}, md.md_op[2] ? abs_a : abs_b};
      end else if (state == CALC && !special) begin
        acc <= acc_n;
        cnt <= cnt + 1'b1;
      end
      if (done) last <= result;
    end
  assign done = (state == DONE) & !md.flush;
  assign md.md_done = done;
  assign md.md_ready = state == IDLE;
  assign md.md_busy = state != IDLE;
  assign md.md_o = done ? result : last;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic clk, rstn;
  int cyc = 0, checks = 0, passes = 0;
  logic [31:0] last_exp = '0;
  typedef struct {logic [31:0] exp; int lat; int cyc;} exp_t;
  exp_t sb[$];
  muldiv_unit_if #(.XLEN(32)) md();
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rstn(rstn), .md(md.slave));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    ia = a; ib = b; sa = ia; sb = ib;
    ua = {32'b0, a}; ub = {32'b0, b};
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    p = op == 3'd2 ? sa * ub : op == 3'd3 ? ua * ub : sa * sb;
    case (op)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return b == 0 ? 32'hFFFFFFFF : ovf ? a : 32'(ia / ib);
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 32;
  endfunction
  always @(negedge clk) if (md.md_done) begin
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL unexpected_done: got md_done=1 md_o=%h required no pulse", md.md_o);
    end else begin
      exp_t e;
      e = sb.pop_front();
      check("md_o", md.md_o, e.exp);
      check("done_latency", 32'(cyc - e.cyc), 32'(e.lat));
      check("busy_in_done", {31'b0, md.md_busy}, 32'd1);
      last_exp = e.exp;
    end
  end
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit track, output int acc);
    bit r;
    int n;
    md.md_valid = 1; md.md_op = op; md.op_A = a; md.op_B = b;
    r = 0; n = 0;
    while (!r && n < 200) begin
      @(negedge clk);
      r = md.md_ready;
      @(posedge clk);
      n++;
    end
    #1;
    acc = cyc;
    md.md_valid = 0;
    if (!r) begin
      checks++;
      $display("FAIL accept_timeout: got no md_ready in 200 cycles required acceptance");
    end else if (track) sb.push_back('{model(op, a, b), lat_of(op, a, b), cyc});
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(md.md_ready && sb.size() == 0) && n < 200);
    if (n >= 200) begin
      checks++;
      $display("FAIL idle_timeout: got busy after 200 cycles required idle");
    end
    @(posedge clk); #1;
  endtask
  typedef struct {logic [2:0] op; logic [31:0] a; logic [31:0] b;} vec_t;
  vec_t dir[$] = '{
    '{3'd1, 32'h80000000, 32'h80000000}, '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF}, '{3'd4, 32'hFFFFFFF9, 32'd2},
    '{3'd6, 32'hFFFFFFF9, 32'd2},        '{3'd5, 32'hFFFFFFF9, 32'd2},
    '{3'd5, 32'd7, 32'd0},               '{3'd7, 32'd7, 32'd0},
    '{3'd4, 32'h80000000, 32'hFFFFFFFF}, '{3'd6, 32'h80000000, 32'hFFFFFFFF},
    '{3'd4, 32'hFFFFFFF9, 32'd0},        '{3'd6, 32'hFFFFFFF9, 32'd0}
  };
  initial begin
    int c1, c2;
    logic [31:0] a, b;
    rstn = 0; md.md_valid = 0; md.md_op = '0; md.op_A = '0; md.op_B = '0; md.flush = 0;
    #12;
    check("reset_ready", {31'b0, md.md_ready}, 32'd1);
    check("reset_busy", {31'b0, md.md_busy}, 32'd0);
    check("reset_done", {31'b0, md.md_done}, 32'd0);
    check("reset_md_o", md.md_o, 32'd0);
    @(posedge clk); #1 rstn = 1;
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 1, c1);
    check("busy_after_accept", {31'b0, md.md_busy}, 32'd1);
    check("ready_after_accept", {31'b0, md.md_ready}, 32'd0);
    wait_idle();
    foreach (dir[i]) begin
      issue(dir[i].op, dir[i].a, dir[i].b, 1, c1);
      wait_idle();
    end
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      b = $urandom_range(0, 9) == 0 ? 32'h0 : $urandom_range(0, 9) == 0 ? 32'hFFFFFFFF :
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      issue(3'($urandom_range(0, 7)), a, b, 1, c1);
      wait_idle();
    end
    issue(3'd4, 32'd100, 32'd3, 0, c1);
    repeat (9) @(posedge clk);
    #1 md.flush = 1;
    @(negedge clk);
    check("flush_calc_no_done", {31'b0, md.md_done}, 32'd0);
    @(posedge clk); #1 md.flush = 0;
    @(negedge clk);
    check("flush_calc_ready", {31'b0, md.md_ready}, 32'd1);
    check("flush_calc_md_o_held", md.md_o, last_exp);
    @(posedge clk); #1;
    issue(3'd6, 32'd100, 32'd3, 1, c1);
    wait_idle();
    issue(3'd5, 32'd7, 32'd0, 0, c1);
    @(posedge clk); #1 md.flush = 1;
    @(negedge clk);
    check("flush_done_suppressed", {31'b0, md.md_done}, 32'd0);
    check("flush_done_md_o_held", md.md_o, last_exp);
    @(posedge clk); #1 md.flush = 0;
    check("flush_done_ready", {31'b0, md.md_ready}, 32'd1);
    md.md_valid = 1; md.flush = 1; md.md_op = 3'd0; md.op_A = 32'd5; md.op_B = 32'd5;
    @(posedge clk); #1 md.md_valid = 0; md.flush = 0;
    check("flush_beats_accept", {31'b0, md.md_busy}, 32'd0);
    issue(3'd0, 32'd1234, 32'd5678, 1, c1);
    issue(3'd5, 32'd1000, 32'd7, 1, c2);
    check("b2b_accept_gap", 32'(c2 - c1), 32'd34);
    wait_idle();
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 0, c1);
    repeat (10) @(posedge clk);
    #1 rstn = 0;
    #1;
    check("async_rst_busy", {31'b0, md.md_busy}, 32'd0);
    check("async_rst_done", {31'b0, md.md_done}, 32'd0);
    check("async_rst_md_o", md.md_o, 32'd0);
    check("async_rst_ready", {31'b0, md.md_ready}, 32'd1);
    last_exp = '0;
    @(posedge clk); #1 rstn = 1;
    issue(3'd7, 32'd100, 32'd7, 1, c1);
    wait_idle();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
